// File: rtl/mem_game_sequencer.sv
// Memory-game level engine: generates a growing random digit sequence, flashes it,
// then scores the player's answers with per-digit timeout and a limited number of lives.
module mem_game_sequencer #(
  parameter int DIGIT_W     = 4,
  parameter int NUM_LEVELS  = 5,
  parameter int BASE_LEN    = 3,
  parameter int MAX_LEN     = 8,
  parameter int FLASH_CYC   = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int LIVES       = 2
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             session_ok,
  input  logic                             logout,
  input  logic                             start,
  input  logic [DIGIT_W-1:0]               rnd_in,
  input  logic                             punch,
  input  logic [DIGIT_W-1:0]               answer,
  output logic [DIGIT_W-1:0]               flash_num,
  output logic                             flash_valid,
  output logic [DIGIT_W-1:0]               ans_echo,
  output logic [$clog2(NUM_LEVELS+1)-1:0]  level_num,
  output logic [$clog2(LIVES+1)-1:0]       lives_left,
  output logic                             win,
  output logic                             lose,
  output logic                             busy
);

  // state    | meaning
  // IDLE     | no session, all outputs 0
  // READY    | waiting for start of current level
  // GEN      | capturing one random digit per cycle
  // FLASH    | showing seq_buf[idx] for FLASH_CYC cycles
  // GAP      | blank for GAP_CYC cycles after each digit
  // ANSWER   | scoring punched digits, per-digit timeout running
  // LEVEL_OK | one-cycle level advance / win decision
  // WIN      | game won, waiting for start
  // LOSE     | lives exhausted, waiting for start
  typedef enum logic [3:0] {
    IDLE, READY, GEN, FLASH, GAP, ANSWER, LEVEL_OK, WIN, LOSE
  } state_t;

  localparam int LVL_W   = $clog2(NUM_LEVELS + 1);
  localparam int LIV_W   = $clog2(LIVES + 1);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_MAX = (FLASH_CYC > GAP_CYC) ? FLASH_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 2);
  localparam int TO_LOAD = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam bit TO_EN   = (TIMEOUT_CYC > 0);

  state_t             state;
  logic [DIGIT_W-1:0] seq_buf [MAX_LEN];
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   tmr;
  logic [TO_W-1:0]    to_cnt;
  logic [IDX_W-1:0]   last_idx;
  logic               hit;
  logic               expired;
  int                 len_i;

  // sequence length saturates at MAX_LEN; level 0 only occurs outside play
  always_comb begin
    len_i = BASE_LEN + int'(level_num) - 1;
    if (len_i > MAX_LEN) len_i = MAX_LEN;
    if (len_i < 1) len_i = 1;
    last_idx = IDX_W'(len_i - 1);
    hit      = (answer == seq_buf[idx]);
    expired  = TO_EN && (to_cnt == '0);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      tmr         <= '0;
      to_cnt      <= '0;
      flash_num   <= '0;
      flash_valid <= 1'b0;
      ans_echo    <= '0;
      level_num   <= '0;
      lives_left  <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seq_buf[i] <= '0;
    end else if (logout || !session_ok) begin
      state       <= IDLE;
      idx         <= '0;
      tmr         <= '0;
      to_cnt      <= '0;
      flash_num   <= '0;
      flash_valid <= 1'b0;
      ans_echo    <= '0;
      level_num   <= '0;
      lives_left  <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ans_echo <= answer;
      case (state)
        IDLE: begin
          ans_echo   <= '0;
          state      <= READY;
          level_num  <= LVL_W'(1);
          lives_left <= LIV_W'(LIVES);
        end
        READY: begin
          if (start) begin
            state <= GEN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        GEN: begin
          seq_buf[idx] <= rnd_in;
          if (idx == last_idx) begin
            state       <= FLASH;
            idx         <= '0;
            tmr         <= TMR_W'(FLASH_CYC - 1);
            flash_valid <= 1'b1;
            // with a one-digit sequence buf[0] is being written this very edge
            flash_num   <= (last_idx == '0) ? rnd_in : seq_buf[0];
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        FLASH: begin
          if (tmr == '0) begin
            state       <= GAP;
            tmr         <= TMR_W'(GAP_CYC - 1);
            flash_valid <= 1'b0;
            flash_num   <= '0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else if (idx == last_idx) begin
            state  <= ANSWER;
            idx    <= '0;
            to_cnt <= TO_W'(TO_LOAD);
            busy   <= 1'b0;
          end else begin
            state       <= FLASH;
            idx         <= idx + IDX_W'(1);
            tmr         <= TMR_W'(FLASH_CYC - 1);
            flash_valid <= 1'b1;
            flash_num   <= seq_buf[idx + IDX_W'(1)];
          end
        end
        ANSWER: begin
          // a punch always wins over a coincident timeout
          if (punch && hit) begin
            if (idx == last_idx) begin
              state <= LEVEL_OK;
            end else begin
              idx    <= idx + IDX_W'(1);
              to_cnt <= TO_W'(TO_LOAD);
            end
          end else if (punch || expired) begin
            lives_left <= lives_left - LIV_W'(1);
            if (lives_left == LIV_W'(1)) begin
              state <= LOSE;
              lose  <= 1'b1;
            end else begin
              state       <= FLASH;
              idx         <= '0;
              tmr         <= TMR_W'(FLASH_CYC - 1);
              flash_valid <= 1'b1;
              flash_num   <= seq_buf[0];
              busy        <= 1'b1;
            end
          end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        LEVEL_OK: begin
          if (level_num == LVL_W'(NUM_LEVELS)) begin
            state <= WIN;
            win   <= 1'b1;
          end else begin
            state     <= READY;
            level_num <= level_num + LVL_W'(1);
          end
        end
        WIN, LOSE: begin
          if (start) begin
            state      <= GEN;
            idx        <= '0;
            level_num  <= LVL_W'(1);
            lives_left <= LIV_W'(LIVES);
            win        <= 1'b0;
            lose       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_game_sequencer.sv
// Directed bench for mem_game_sequencer with default parameters; expected values are
// hand-derived from the level/flash/answer timing of the engine.
module tb_mem_game_sequencer;

  logic       clock = 1'b0;
  logic       rst, session_ok, logout, start, punch;
  logic [3:0] rnd_in, answer;
  logic [3:0] flash_num, ans_echo;
  logic       flash_valid, win, lose, busy;
  logic [2:0] level_num;
  logic [1:0] lives_left;

  int total = 0;
  int bad   = 0;
  logic [3:0]  exp_seq [8];
  logic [31:0] pats [5];

  mem_game_sequencer dut (
    .clock(clock), .rst(rst), .session_ok(session_ok), .logout(logout),
    .start(start), .rnd_in(rnd_in), .punch(punch), .answer(answer),
    .flash_num(flash_num), .flash_valid(flash_valid), .ans_echo(ans_echo),
    .level_num(level_num), .lives_left(lives_left), .win(win), .lose(lose),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_seq(input logic [31:0] pat);
    for (int i = 0; i < 8; i++) exp_seq[i] = pat[4*i +: 4];
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic gen_seq(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_in = exp_seq[i];
      tick();
    end
  endtask

  task automatic flash_seq(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (8) begin
        chk("flash_on", 32'({flash_valid, flash_num}), 32'({1'b1, exp_seq[i]}));
        tick();
      end
      repeat (2) begin
        chk("flash_gap", 32'({flash_valid, flash_num}), 32'h0);
        tick();
      end
    end
  endtask

  task automatic do_punch(input logic [3:0] v);
    answer = v;
    punch  = 1'b1;
    tick();
    punch  = 1'b0;
  endtask

  task automatic answer_all(input int n);
    for (int i = 0; i < n; i++) do_punch(exp_seq[i]);
  endtask

  initial begin
    pats[0] = 32'h0000_04D3;
    pats[1] = 32'h0000_9A1E;
    pats[2] = 32'h0005_27B6;
    pats[3] = 32'h008C_0F31;
    pats[4] = 32'h06E2_A97D;
    rst = 1'b1; session_ok = 1'b0; logout = 1'b0; start = 1'b0;
    punch = 1'b0; rnd_in = 4'h0; answer = 4'h0;
    tick(); tick();
    chk("rst_level", 32'(level_num), 32'd0);
    chk("rst_lives", 32'(lives_left), 32'd0);
    chk("rst_flags", 32'({win, lose, busy, flash_valid}), 32'h0);
    chk("rst_data", 32'({flash_num, ans_echo}), 32'h0);

    rst = 1'b0; session_ok = 1'b1; answer = 4'h7;
    tick();
    chk("ready_level", 32'(level_num), 32'd1);
    chk("ready_lives", 32'(lives_left), 32'd2);
    chk("ready_flags", 32'({win, lose, flash_valid, flash_num}), 32'h0);
    tick();
    chk("ans_echo", 32'(ans_echo), 32'h7);

    // level 1 played cleanly
    load_seq(pats[0]);
    start_pulse();
    chk("gen_busy", 32'(busy), 32'd1);
    gen_seq(3);
    flash_seq(3);
    chk("answer_busy", 32'(busy), 32'd0);
    answer_all(3);
    tick();
    chk("l1_level", 32'(level_num), 32'd2);
    chk("l1_lives", 32'(lives_left), 32'd2);
    chk("l1_busy", 32'(busy), 32'd0);

    // re-login, miss on first digit, replay, then pass
    session_ok = 1'b0; tick();
    chk("logoff_level", 32'(level_num), 32'd0);
    session_ok = 1'b1; tick();
    chk("relog_level", 32'(level_num), 32'd1);
    start_pulse();
    gen_seq(3);
    flash_seq(3);
    do_punch(4'h5);
    chk("miss_lives", 32'(lives_left), 32'd1);
    flash_seq(3);
    answer_all(3);
    tick();
    chk("replay_level", 32'(level_num), 32'd2);
    chk("replay_lives", 32'(lives_left), 32'd1);

    // level 2 with one life: timeout leads to LOSE
    load_seq(pats[1]);
    start_pulse();
    gen_seq(4);
    flash_seq(4);
    repeat (63) tick();
    chk("pre_to_lose", 32'(lose), 32'd0);
    chk("pre_to_lives", 32'(lives_left), 32'd1);
    tick();
    chk("to_lose", 32'(lose), 32'd1);
    repeat (5) tick();
    chk("lose_held", 32'({lose, busy}), 32'h2);
    start_pulse();
    chk("restart_lose", 32'(lose), 32'd0);
    chk("restart_level", 32'(level_num), 32'd1);
    chk("restart_lives", 32'(lives_left), 32'd2);
    chk("restart_busy", 32'(busy), 32'd1);

    // full game to WIN, lengths 3..7; level 3 punches exactly on timeout expiry
    for (int lv = 0; lv < 5; lv++) begin
      load_seq(pats[lv]);
      if (lv != 0) start_pulse();
      gen_seq(lv + 3);
      flash_seq(lv + 3);
      if (lv == 2) begin
        repeat (63) tick();
        do_punch(exp_seq[0]);
        chk("to_tie_lives", 32'(lives_left), 32'd2);
        chk("to_tie_flash", 32'(flash_valid), 32'd0);
        for (int i = 1; i < 5; i++) do_punch(exp_seq[i]);
      end else begin
        answer_all(lv + 3);
      end
      tick();
      if (lv < 4) chk("lvl_adv", 32'(level_num), 32'(lv + 2));
    end
    chk("win", 32'(win), 32'd1);
    chk("win_level", 32'(level_num), 32'd5);
    chk("win_lives", 32'(lives_left), 32'd2);
    do_punch(4'h0);
    tick();
    chk("win_punch", 32'({win, lose, busy}), 32'h4);
    chk("win_punch_lvl", 32'(level_num), 32'd5);

    // logout mid-FLASH
    load_seq(pats[0]);
    start_pulse();
    chk("win_cleared", 32'(win), 32'd0);
    gen_seq(3);
    repeat (3) tick();
    chk("mid_flash", 32'({flash_valid, flash_num}), 32'h13);
    logout = 1'b1; tick(); logout = 1'b0;
    chk("logout_flash", 32'({flash_valid, flash_num}), 32'h0);
    chk("logout_level", 32'(level_num), 32'd0);
    chk("logout_misc", 32'({lives_left, busy, win, lose}), 32'h0);
    tick();
    chk("relog2_level", 32'(level_num), 32'd1);

    // rst mid-ANSWER, then a punch that must be ignored
    start_pulse();
    gen_seq(3);
    flash_seq(3);
    answer = 4'h9; tick();
    chk("answer_echo", 32'(ans_echo), 32'h9);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_level", 32'(level_num), 32'd0);
    chk("rst2_all", 32'({lives_left, win, lose, busy, flash_valid, flash_num, ans_echo}), 32'h0);
    do_punch(exp_seq[0]);
    chk("post_rst_lvl", 32'(level_num), 32'd1);
    chk("post_rst_lives", 32'(lives_left), 32'd2);
    tick();
    chk("post_rst_idle", 32'({busy, flash_valid, win, lose}), 32'h0);
    chk("post_rst_lvl2", 32'(level_num), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_game_sequencer.md
Name: mem_game_sequencer

Overview:
Parametrised memory-game level engine.
- Captures a random digit sequence whose length grows per level, flashes it, then checks the player's punched-in answers digit by digit.
- Adds features the fixed-size engine lacks: configurable digit width, level count and sequence depth; per-digit answer timeout; multiple lives with replay-on-miss; win/lose restart without re-login.
- Sits between the login/authentication block and the seven-segment drivers.

Parameters:
DIGIT_W, 4, width of each sequence digit and answer
NUM_LEVELS, 5, number of levels to win
BASE_LEN, 3, sequence length at level 1; length = min(BASE_LEN+level-1, MAX_LEN)
MAX_LEN, 8, sequence buffer depth (registers)
FLASH_CYC, 8, cycles each digit is displayed
GAP_CYC, 2, blank cycles after each digit
TIMEOUT_CYC, 64, max cycles per answer digit in ANSWER; 0 disables timeout
LIVES, 2, misses allowed per game, ≥1

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
session_ok  in  1  authenticated user logged in (level-sensitive)
logout  in  1  single-cycle pulse, ends session
start  in  1  single-cycle pulse (debounced upstream), starts a level
rnd_in  in  DIGIT_W  random source, sampled in GEN
punch  in  1  single-cycle pulse, submits answer
answer  in  DIGIT_W  player toggle value
flash_num  out  DIGIT_W  digit being flashed, 0 when not flashing
flash_valid  out  1  high while a digit is displayed
ans_echo  out  DIGIT_W  answer registered every cycle, for segment echo
level_num  out  $clog2(NUM_LEVELS+1)  current level, 0 when logged out
lives_left  out  $clog2(LIVES+1)  remaining lives
win  out  1  held high in WIN
lose  out  1  held high in LOSE
busy  out  1  high in GEN/FLASH/GAP

Behaviour:
- Reset: state IDLE. All outputs 0, sequence buffer cleared, counters 0.
- Priority each cycle: rst > (logout or !session_ok) > state logic. The logout condition in any non-IDLE state means next state IDLE and all outputs 0.
- IDLE → READY when session_ok=1 and logout=0. On entry to READY: level_num=1, lives_left=LIVES.
- READY: start → GEN, idx=0.
- GEN: one cycle per digit. buf[idx]=rnd_in for len cycles, then → FLASH with idx=0. The sequence is regenerated only on a fresh start, never on replay.
- FLASH: flash_num=buf[idx], flash_valid=1 for exactly FLASH_CYC cycles, then → GAP.
- GAP: flash_num=0, flash_valid=0 for GAP_CYC cycles. Then idx+1 → FLASH, or after the last digit → ANSWER with idx=0 and the timeout counter cleared.
- ANSWER: on punch, compare answer with buf[idx].
  - Match and idx<len-1: idx++, timeout counter cleared.
  - Match and idx=len-1: → LEVEL_OK.
  - Mismatch, or timeout counter reaching TIMEOUT_CYC: lives_left-1. If the result is 0 → LOSE; else → FLASH replaying the same sequence from idx=0.
  - Punch and timeout expiry in the same cycle: the punch is evaluated and the timeout is ignored.
- LEVEL_OK, 1 cycle: if level_num=NUM_LEVELS → WIN; else level_num+1 → READY. Lives are not restored between levels.
- WIN/LOSE: win or lose held high. start → GEN with level_num=1, lives_left=LIVES, win/lose cleared the same edge.
- punch ignored outside ANSWER. start ignored outside READY/WIN/LOSE.
- len is computed with saturation at MAX_LEN. Levels beyond the saturation point replay MAX_LEN digits.
- ans_echo = answer delayed one cycle, in every state except IDLE, where it is 0.
- busy=1 exactly in GEN, FLASH and GAP.

Test Plan:
- Defaults; rst 1 cycle then session_ok=1 → next cycle level_num=1, lives_left=2; win, lose, flash_valid, flash_num all 0.
- start; rnd_in=3,D,4 over 3 GEN cycles → flash_num=3 for 8 cycles, 0 for 2, then D, then 4. Punch 3,D,4 in ANSWER → level_num=2, state READY, lives_left=2.
- Level 1, punch answer=5 as first digit → lives_left=1; sequence 3,D,4 flashed again unchanged. Correct entry → level_num=2.
- lives_left=1 in ANSWER, no punch for 64 cycles → lose=1 held. Next start → lose=0, level_num=1, lives_left=2, busy=1.
- Five levels answered correctly, lengths 3,4,5,6,7 → win=1 after level 5 LEVEL_OK; further punch has no effect. Punch coinciding with timeout expiry is scored as a punch.
- logout pulse mid-FLASH → next cycle flash_valid=0, level_num=0, IDLE. rst asserted mid-ANSWER → all outputs 0 next cycle; a subsequent punch is ignored.
